// File: rtl/dct_row_butterfly_pkg.sv
// -----------------------------------------------------------------------------
// dct_row_butterfly_pkg
// Shared types and constants for the stage-1 row butterfly of the 8x8 DCT.
//   PKG_DATA_W / PKG_LEVEL : default sample width and level-shift offset
//   BFLY_PAIRS             : butterfly pairs per 8-sample row
//   bfly_t / row_bfly_t    : one pair result / all four pair results of a row
//   bfly_state_e           : control states of the pair sequencer
//   ARRIVAL_ORDER          : column index of each sample in arrival order
// -----------------------------------------------------------------------------
package dct_row_butterfly_pkg;

    localparam int PKG_DATA_W = 8;
    localparam int PKG_LEVEL  = 128;
    localparam int BFLY_PAIRS = 4;
    localparam int ROW_LEN    = 2 * BFLY_PAIRS;

    typedef struct packed {
        logic signed [PKG_DATA_W:0] sum;
        logic signed [PKG_DATA_W:0] diff;
    } bfly_t;

    typedef bfly_t row_bfly_t [BFLY_PAIRS];

    typedef enum logic {
        WAIT_A = 1'b0,   // expecting x_k (even arrival slot)
        WAIT_B = 1'b1    // expecting x_(7-k) (odd arrival slot)
    } bfly_state_e;

    // Samples of a row arrive as x0,x7,x1,x6,x2,x5,x3,x4.
    localparam int ARRIVAL_ORDER [ROW_LEN] = '{0, 7, 1, 6, 2, 5, 3, 4};

endpackage

// File: rtl/dct_row_butterfly_pair_bfly.sv
// -----------------------------------------------------------------------------
// pair_bfly
// Combinational level shift plus add/subtract for one butterfly pair.
// Time-shared across the four pairs of a row by the parent.
//   i_sample : raw unsigned sample (the second sample of a pair when used)
//   i_held   : level-shifted first sample of the pair, x_k
//   o_xs     : level-shifted i_sample
//   o_sum    : x_k + x_(7-k)
//   o_diff   : x_k - x_(7-k)
// -----------------------------------------------------------------------------
module pair_bfly #(
    parameter int DATA_W = 8,
    parameter int LEVEL  = 128
) (
    input  logic [DATA_W-1:0]    i_sample,
    input  logic signed [DATA_W:0] i_held,
    output logic signed [DATA_W:0] o_xs,
    output logic signed [DATA_W:0] o_sum,
    output logic signed [DATA_W:0] o_diff
);

    localparam logic signed [DATA_W:0] LEVEL_S = LEVEL[DATA_W:0];

    // Both operands lie in -LEVEL..LEVEL-1, so DATA_W+1 bits hold the full
    // sum/difference range without any saturation.
    assign o_xs   = $signed({1'b0, i_sample}) - LEVEL_S;
    assign o_sum  = i_held + o_xs;
    assign o_diff = i_held - o_xs;

endmodule

// File: rtl/dct_row_butterfly.sv
// -----------------------------------------------------------------------------
// dct_row_butterfly
// Collects one 8-sample row arriving in butterfly pair order, level-shifts
// each sample, forms s_k = x_k + x_(7-k) and d_k = x_k - x_(7-k) and presents
// the whole row in parallel with a one-cycle out_valid pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of counters, hold and working registers
//   in_valid   : sample strobe (no backpressure)
//   in_data    : unsigned sample
//   out_valid  : one-cycle pulse, row result valid
//   out_sum    : s_k in slot k, bits [k*(DATA_W+1) +: DATA_W+1]
//   out_diff   : d_k in slot k, same packing as out_sum
//   out_row    : row index of the result within the 8x8 block
//   out_last   : high with out_valid for row 7
// -----------------------------------------------------------------------------
module dct_row_butterfly
    import dct_row_butterfly_pkg::*;
#(
    // The working registers use bfly_t, so DATA_W must match PKG_DATA_W.
    parameter int DATA_W = PKG_DATA_W,
    parameter int LEVEL  = PKG_LEVEL
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [DATA_W-1:0]                  in_data,
    output logic                               out_valid,
    output logic [BFLY_PAIRS*(DATA_W+1)-1:0]   out_sum,
    output logic [BFLY_PAIRS*(DATA_W+1)-1:0]   out_diff,
    output logic [2:0]                         out_row,
    output logic                               out_last
);

    localparam int W = DATA_W + 1;

    bfly_state_e           r_state;
    bfly_state_e           w_state_nxt;
    logic [2:0]            r_smp_cnt;
    logic [2:0]            r_row_cnt;
    logic signed [DATA_W:0] r_hold;
    row_bfly_t             r_work;
    logic                  w_accept;
    logic                  w_row_done;
    logic [1:0]            w_pair_idx;
    logic signed [DATA_W:0] w_xs;
    logic signed [DATA_W:0] w_sum;
    logic signed [DATA_W:0] w_diff;

    logic                          r_out_valid;
    logic [BFLY_PAIRS*W-1:0]       r_out_sum;
    logic [BFLY_PAIRS*W-1:0]       r_out_diff;
    logic [2:0]                    r_out_row;
    logic                          r_out_last;

    // flush wins over a coincident sample, which is dropped.
    assign w_accept   = in_valid && !flush;
    assign w_pair_idx = r_smp_cnt[2:1];

    pair_bfly #(
        .DATA_W (DATA_W),
        .LEVEL  (LEVEL)
    ) u_pair_bfly (
        .i_sample (in_data),
        .i_held   (r_hold),
        .o_xs     (w_xs),
        .o_sum    (w_sum),
        .o_diff   (w_diff)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_row_done  = 1'b0;
        if (flush) begin
            w_state_nxt = WAIT_A;
        end else if (in_valid) begin
            case (r_state)
                WAIT_A: w_state_nxt = WAIT_B;
                WAIT_B: begin
                    w_state_nxt = WAIT_A;
                    w_row_done  = (r_smp_cnt == 3'd7);
                end
                default: w_state_nxt = WAIT_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, hold register and working slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_cnt <= '0;
            r_row_cnt <= '0;
            r_hold    <= '0;
            for (int k = 0; k < BFLY_PAIRS; k++) r_work[k] <= '0;
        end else if (flush) begin
            r_smp_cnt <= '0;
            r_row_cnt <= '0;
            r_hold    <= '0;
            for (int k = 0; k < BFLY_PAIRS; k++) r_work[k] <= '0;
        end else if (w_accept) begin
            r_smp_cnt <= r_smp_cnt + 3'd1;
            if (r_state == WAIT_A) begin
                r_hold <= w_xs;
            end else begin
                r_work[w_pair_idx] <= '{sum: w_sum, diff: w_diff};
            end
            if (w_row_done) r_row_cnt <= r_row_cnt + 3'd1;
        end
    end

    // Output registers: loaded only on row completion, held otherwise.
    // Pair 3 is taken straight from the butterfly since its slot is only
    // written on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_diff  <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= w_row_done;
            if (w_row_done) begin
                for (int k = 0; k < BFLY_PAIRS - 1; k++) begin
                    r_out_sum[k*W +: W]  <= r_work[k].sum;
                    r_out_diff[k*W +: W] <= r_work[k].diff;
                end
                r_out_sum[(BFLY_PAIRS-1)*W +: W]  <= w_sum;
                r_out_diff[(BFLY_PAIRS-1)*W +: W] <= w_diff;
                r_out_row  <= r_row_cnt;
                r_out_last <= (r_row_cnt == 3'd7);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_diff  = r_out_diff;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_dct_row_butterfly.sv
// -----------------------------------------------------------------------------
// tb_dct_row_butterfly
// Self-checking bench: directed rows plus randomized rows, gaps, flushes and
// resets, compared every cycle against a reference model that places each
// arriving sample into its column x[0..7] and computes the butterflies.
// -----------------------------------------------------------------------------
module tb_dct_row_butterfly;
    import dct_row_butterfly_pkg::*;

    localparam int DW = PKG_DATA_W;
    localparam int W  = DW + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic [4*W-1:0]    out_sum;
    logic [4*W-1:0]    out_diff;
    logic [2:0]        out_row;
    logic              out_last;

    dct_row_butterfly dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_cnt, m_row;
    int m_x [8];
    int m_sum [4];
    int m_diff [4];
    int m_orow, m_last, m_pulse;
    int d_pulses = 0, d_lasts = 0;

    task automatic model_reset();
        m_cnt = 0; m_row = 0; m_orow = 0; m_last = 0; m_pulse = 0;
        for (int i = 0; i < 8; i++) m_x[i] = 0;
        for (int k = 0; k < 4; k++) begin m_sum[k] = 0; m_diff[k] = 0; end
    endtask

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_step();
        m_pulse = 0;
        if (flush) begin
            m_cnt = 0;
            m_row = 0;
        end else if (in_valid) begin
            m_x[ARRIVAL_ORDER[m_cnt]] = int'(in_data) - PKG_LEVEL;
            m_cnt++;
            if (m_cnt == 8) begin
                for (int k = 0; k < 4; k++) begin
                    m_sum[k]  = m_x[k] + m_x[7-k];
                    m_diff[k] = m_x[k] - m_x[7-k];
                end
                m_orow  = m_row;
                m_last  = (m_row == 7) ? 1 : 0;
                m_row   = (m_row + 1) % 8;
                m_cnt   = 0;
                m_pulse = 1;
            end
        end
    endtask

    function automatic int slot(input logic [4*W-1:0] v, input int k);
        logic signed [W-1:0] s;
        s = v[k*W +: W];
        return int'(s);
    endfunction

    task automatic compare_all();
        check("out_valid", int'(out_valid), m_pulse);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sum%0d", k),  slot(out_sum, k),  m_sum[k]);
            check($sformatf("diff%0d", k), slot(out_diff, k), m_diff[k]);
        end
        check("out_row",  int'(out_row),  m_orow);
        check("out_last", int'(out_last), m_last);
        if (out_valid === 1'b1) d_pulses++;
        if (out_valid === 1'b1 && out_last === 1'b1) d_lasts++;
    endtask

    // ---------------- drivers ----------------
    // Entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, DW'($urandom), 1'b0);
    endtask

    // vals are in arrival order; gap_len idle cycles are inserted before
    // arrival slot gap_at.
    task automatic send_row(input int vals [8], input int gap_at, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) idle(gap_len);
            cycle(1'b1, DW'(vals[i]), 1'b0);
        end
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, DW'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    int row_v [8];
    int p0, l0;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        idle(2);

        // All samples at the level -> all zeros, row 0, not last.
        row_v = '{128, 128, 128, 128, 128, 128, 128, 128};
        send_row(row_v, -1, 0);
        check("flat_row", int'(out_row), 0);
        check("flat_s0", slot(out_sum, 0), 0);
        idle(1);

        // Ramp x_k = 32k.
        row_v = '{0, 224, 32, 192, 64, 160, 96, 128};
        send_row(row_v, -1, 0);
        check("ramp_s0", slot(out_sum, 0), -32);
        check("ramp_s3", slot(out_sum, 3), -32);
        check("ramp_d0", slot(out_diff, 0), -224);
        check("ramp_d1", slot(out_diff, 1), -160);
        check("ramp_d2", slot(out_diff, 2), -96);
        check("ramp_d3", slot(out_diff, 3), -32);
        idle(3);

        // Extremes.
        row_v = '{255, 0, 128, 128, 128, 128, 128, 128};
        send_row(row_v, -1, 0);
        check("ext_s0", slot(out_sum, 0), -1);
        check("ext_d0", slot(out_diff, 0), 255);
        check("ext_s1", slot(out_sum, 1), 0);
        idle(2);

        // Full block back to back from row 0, then a 65th row.
        do_reset();
        p0 = d_pulses; l0 = d_lasts;
        send_random(64);
        idle(1);
        check("blk_pulses", d_pulses - p0, 8);
        check("blk_lasts",  d_lasts - l0, 1);
        send_random(8);
        check("row65_row", int'(out_row), 0);

        // Gap of 5 after the third sample.
        row_v = '{0, 224, 32, 192, 64, 160, 96, 128};
        send_row(row_v, 3, 5);
        check("gap_d0", slot(out_diff, 0), -224);

        // Reset mid-row.
        send_random(5);
        do_reset();
        send_random(8);
        check("rst_row", int'(out_row), 0);

        // Flush mid-row, idle and with a coincident sample.
        send_random(13);
        cycle(1'b0, DW'($urandom), 1'b1);
        send_random(8);
        check("flush_row", int'(out_row), 0);
        send_random(5);
        cycle(1'b1, DW'($urandom), 1'b1);
        send_random(8);
        check("flushv_row", int'(out_row), 0);

        // Randomized traffic: gaps, occasional flushes and one reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            else cycle(($urandom_range(3) != 0), DW'($urandom),
                       ($urandom_range(60) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dct_row_butterfly.md
Name: dct_row_butterfly

Overview:
- Downstream consumer of one colour channel from the ping-pong line buffer.
- Input samples arrive serially, one 8x8 block at a time, row by row.
- Within each row, samples arrive in butterfly pair order: x0,x7,x1,x6,x2,x5,x3,x4.
- The block level-shifts each sample, forms the stage-1 DCT butterfly sums and differences per row, and presents all 8 results in parallel to the row-DCT multiplier stage.
- Three instances are used, one per channel.

Parameters:
- DATA_W, 8, width of the unsigned input sample.
- LEVEL, 128, level-shift offset subtracted from every sample.

Ports:
- clk  in  1  single clock (the read-side clock of the line buffer)
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of sample/row counters and the pending half-pair
- in_valid  in  1  sample strobe; no backpressure exists
- in_data  in  DATA_W  unsigned sample
- out_valid  out  1  one-cycle pulse: a row result is valid
- out_sum  out  4x(DATA_W+1)  signed s_k = x_k + x_(7-k), k=0..3
- out_diff  out  4x(DATA_W+1)  signed d_k = x_k - x_(7-k), k=0..3
- out_row  out  3  row index of the result within the current 8x8 block
- out_last  out  1  high with out_valid for row 7 (block complete)

Behaviour:
- Reset: all outputs 0; smp_cnt=0; row_cnt=0; held sample=0.
- Level shift: xs = in_data - LEVEL, signed, DATA_W+1 bits.
- Sums and differences are DATA_W+1 bits. Range for DATA_W=8 is -256..255, so no overflow and no saturation logic.
- smp_cnt (0..7) advances only on in_valid and wraps 7->0.
- Even smp_cnt: latch xs into hold register a.
- Odd smp_cnt: compute pair k = smp_cnt>>1 from (a, xs). Write s_k and d_k into the working register slot k.
- On the sample with smp_cnt==7:
  - copy all working slots, including pair 3 computed this cycle, into the output registers on the next edge;
  - out_valid=1 for exactly one cycle, 1 cycle after that sample;
  - out_row = row_cnt; out_last = (row_cnt==7);
  - row_cnt increments and wraps 7->0.
- Output registers hold their value between pulses and change only on a new row completion.
- The next row may start on the cycle immediately after the 8th sample. Sustained throughput is 1 sample/clk.
- Gaps: in_valid low mid-row pauses all counters. Partial state is retained indefinitely; there is no timeout.
- flush:
  - smp_cnt=0, row_cnt=0, working slots cleared;
  - output registers unchanged; out_valid forced 0 that cycle.
  - flush and in_valid together: flush wins and the sample is dropped.
- Reset asserted mid-row: everything returns to reset values immediately (asynchronous). The first valid sample after deassertion is x0 of row 0.
- Control is a 2-state FSM:
  - WAIT_A: expecting the even sample of a pair.
  - WAIT_B: expecting the odd sample of a pair.
  - Transitions occur on in_valid only.
  - smp_cnt==7 in WAIT_B raises row_done internally.

Decomposition:
- Shared package holds:
  - constant BFLY_PAIRS=4;
  - typedef bfly_t, a struct of signed [DATA_W:0] sum and diff;
  - typedef row_bfly_t = bfly_t[4];
  - the arrival-order constant table {0,7,1,6,2,5,3,4} for benches.
- One natural sub-module, pair_bfly: combinational level shift plus add/sub for one pair, instantiated once and time-shared by k.
- Counters and the FSM stay in the top.

Test Plan:
- All samples 128 for one row -> one out_valid pulse, 1 cycle after the 8th sample; all sums/diffs 0; out_row=0; out_last=0.
- Ramp x_k=32k, sent as 0,224,32,192,64,160,96,128 -> s=(-32,-32,-32,-32), d=(-224,-160,-96,-32).
- Extremes x0=255, x7=0, others 128 -> s0=-1, d0=255, remaining pairs 0.
- 64 back-to-back samples:
  - 8 pulses spaced exactly 8 cycles apart, out_row 0..7;
  - out_last only on the 8th pulse;
  - a 65th row restarts out_row at 0.
- in_valid low for 5 cycles after sample 3 -> result identical to the gapless case; pulse delayed by 5 cycles.
- Reset after sample 5, or flush after sample 5 (flush also with in_valid=1) -> no pulse for the partial row; the next 8 samples yield out_row=0 with correct values.
